// File: rtl/mat_pkg.sv
// Shared types and index helpers for the matrix operand loader and its mat_mult consumer.
// Matrices are carried as unpacked int [0:N-1][0:N-1] arrays, sized by each module's own N.
package mat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_RUN,
    ST_DONE
  } loader_state_e;

  // Row-major element index to row / column of an n x n matrix.
  function automatic int idx_row(input int idx, input int n);
    return idx / n;
  endfunction

  function automatic int idx_col(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/mat_loader.sv
// Streams A then B (row-major) into two int operand arrays, B stored transposed,
// then holds them stable while asserting mat_mult's enable for RUN_CYCLES cycles.
module mat_loader
  import mat_pkg::*;
#(
  parameter int N          = 2,
  parameter int DW         = 8,
  parameter int RUN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 enable,
  output logic                 done,
  output int                   mat1 [0:N-1][0:N-1],
  output int                   mat2 [0:N-1][0:N-1]
);

  localparam int CW  = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int RCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(N * N - 1);
  localparam logic [RCW-1:0] LAST_RUN = RCW'(RUN_CYCLES - 1);

  loader_state_e  state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [RCW-1:0] run_cnt_reg;
  logic           enable_reg;
  logic           done_reg;
  logic           xfer;
  logic           last_elem;
  logic [IW-1:0]  row;
  logic [IW-1:0]  col;

  assign in_ready  = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
  assign busy      = (state_reg != ST_IDLE);
  assign enable    = enable_reg;
  assign done      = done_reg;

  assign xfer      = in_valid && in_ready;
  assign last_elem = (cnt_reg == LAST_IDX);
  assign row       = IW'(idx_row(int'(cnt_reg), N));
  assign col       = IW'(idx_col(int'(cnt_reg), N));

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:   if (start) state_next = ST_LOAD_A;
      ST_LOAD_A: if (xfer && last_elem) state_next = ST_LOAD_B;
      ST_LOAD_B: if (xfer && last_elem) state_next = ST_RUN;
      ST_RUN:    if (run_cnt_reg == LAST_RUN) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      run_cnt_reg <= '0;
      enable_reg  <= 1'b0;
      done_reg    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          mat1[i][j] <= 0;
          mat2[i][j] <= 0;
        end
      end
    end else begin
      state_reg <= state_next;
      // enable/done are registered copies of the next-state decode so they line up with the state.
      enable_reg <= (state_next == ST_RUN);
      done_reg   <= (state_next == ST_DONE);

      if (state_reg == ST_IDLE && start) begin
        cnt_reg <= '0;
      end else if (xfer) begin
        cnt_reg <= last_elem ? '0 : cnt_reg + CW'(1);
      end

      if (state_reg == ST_RUN) run_cnt_reg <= run_cnt_reg + RCW'(1);
      else                     run_cnt_reg <= '0;

      // B lands transposed so each mat2 row is a column of B.
      if (xfer && state_reg == ST_LOAD_A) mat1[row][col] <= int'(in_data);
      if (xfer && state_reg == ST_LOAD_B) mat2[col][row] <= int'(in_data);
    end
  end

endmodule

// File: tb/tb_mat_loader.sv
// Scenario bench for mat_loader: scoreboarded element writes, run timing, start/reset corner cases.
module tb_mat_loader;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, busy, enable, done;
  int mat1 [0:N-1][0:N-1];
  int mat2 [0:N-1][0:N-1];

  int checks = 0;
  int failures = 0;
  int elem_no = 0;

  typedef struct {
    int which;
    int r;
    int c;
    int val;
  } exp_t;
  exp_t sb[$];

  logic [7:0] va [4];
  logic [7:0] vb [4];
  int         ep [4];

  always #5 clk = ~clk;

  mat_loader #(.N(N), .DW(DW), .RUN_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .enable(enable), .done(done),
    .mat1(mat1), .mat2(mat2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sext8(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    elem_no = 0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_latency in_ready=%b busy=%b required 1 1", in_ready, busy);
    end
  endtask

  // One element; the expected destination is queued when the handshake is seen.
  task automatic send(input logic [7:0] v, input int gap, input logic pulse_start);
    int guard;
    exp_t e;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      tick;
    end
    in_valid = 1'b1;
    in_data = v;
    start = pulse_start;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 16) begin
      tick;
      guard++;
    end
    if (guard >= 16) begin
      checks++;
      failures++;
      $display("FAIL send_timeout elem=%0d in_ready=%b required 1", elem_no, in_ready);
    end else begin
      if (elem_no < N * N) e = '{0, elem_no / N, elem_no % N, sext8(v)};
      else e = '{1, (elem_no - N * N) % N, (elem_no - N * N) / N, sext8(v)};
      sb.push_back(e);
      elem_no++;
    end
    tick;
    start = 1'b0;
  endtask

  task automatic load_all(input int gap, input logic start_in_b);
    for (int i = 0; i < 4; i++) send(va[i], (i == 0) ? 0 : gap, 1'b0);
    for (int i = 0; i < 4; i++) send(vb[i], gap, start_in_b && (i == 1));
    in_valid = 1'b0;
  endtask

  task automatic check_run(input logic start_in_run);
    int en_cnt, lat;
    int s1 [0:N-1][0:N-1];
    int s2 [0:N-1][0:N-1];
    logic moved;
    s1 = mat1;
    s2 = mat2;
    en_cnt = 0;
    lat = -1;
    checks++;
    if (enable !== 1'b1) begin
      failures++;
      $display("FAIL enable_first_cycle enable=%b required 1", enable);
    end
    for (int c = 0; c < 16; c++) begin
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (enable === 1'b1) en_cnt++;
      start = start_in_run && (c == 1);
      tick;
    end
    start = 1'b0;
    checks++;
    if (lat != RC) begin
      failures++;
      $display("FAIL done_latency got=%0d required %0d", lat, RC);
    end
    checks++;
    if (en_cnt != RC) begin
      failures++;
      $display("FAIL enable_cycles got=%0d required %0d", en_cnt, RC);
    end
    moved = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat1[i][j] !== s1[i][j] || mat2[i][j] !== s2[i][j]) moved = 1'b1;
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL operands_stable_in_run changed=%b required 0", moved);
    end
  endtask

  task automatic finish_idle(input logic start_in_done);
    start = start_in_done;
    tick;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || enable !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL after_done done=%b busy=%b enable=%b in_ready=%b required 0 0 0 0",
               done, busy, enable, in_ready);
    end
  endtask

  task automatic check_mats;
    exp_t e;
    int got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = (e.which == 0) ? mat1[e.r][e.c] : mat2[e.r][e.c];
      checks++;
      if (got !== e.val) begin
        failures++;
        $display("FAIL mat%0d[%0d][%0d] got=%0d required %0d", e.which + 1, e.r, e.c, got, e.val);
      end
    end
  endtask

  // Downstream product: row i of mat1 dotted with row j of mat2 gives (A*B)[i][j].
  task automatic check_product;
    int p;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p = 0;
        for (int k = 0; k < N; k++) p += mat1[i][k] * mat2[j][k];
        checks++;
        if (p !== ep[i * N + j]) begin
          failures++;
          $display("FAIL product[%0d][%0d] got=%0d required %0d", i, j, p, ep[i * N + j]);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic bad;
    reset = 1'b0;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b in_ready=%b enable=%b done=%b required 0 0 0 0",
               busy, in_ready, enable, done);
    end
    bad = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat1[i][j] !== 0 || mat2[i][j] !== 0) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mats nonzero=%b required 0", bad);
    end
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic;
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    ep = '{19, 22, 43, 50};
    do_start;
    load_all(0, 1'b0);
    check_run(1'b0);
    check_mats;
    check_product;
    finish_idle(1'b0);
  endtask

  task automatic test_sign_ext;
    va = '{8'hFF, 8'h80, 8'h00, 8'h00};
    vb = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_start;
    load_all(0, 1'b0);
    check_run(1'b0);
    checks++;
    if (mat1[0][0] !== -1 || mat1[0][1] !== -128) begin
      failures++;
      $display("FAIL sign_ext got=%0d,%0d required -1,-128", mat1[0][0], mat1[0][1]);
    end
    check_mats;
    finish_idle(1'b0);
  endtask

  task automatic test_backpressure;
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    ep = '{19, 22, 43, 50};
    do_start;
    load_all(2, 1'b0);
    check_run(1'b0);
    check_mats;
    check_product;
    finish_idle(1'b0);
  endtask

  task automatic test_start_ignored;
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    ep = '{19, 22, 43, 50};
    do_start;
    load_all(0, 1'b1);
    check_run(1'b1);
    check_mats;
    check_product;
    finish_idle(1'b0);
  endtask

  task automatic test_reset_mid_load;
    logic bad;
    int dn;
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    do_start;
    for (int i = 0; i < 4; i++) send(va[i], 0, 1'b0);
    send(8'd5, 0, 1'b0);
    send(8'd6, 0, 1'b0);
    in_valid = 1'b1;
    in_data = 8'd7;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset busy=%b in_ready=%b enable=%b done=%b required 0 0 0 0",
               busy, in_ready, enable, done);
    end
    bad = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat1[i][j] !== 0 || mat2[i][j] !== 0) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midload_mats nonzero=%b required 0", bad);
    end
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1 || busy === 1'b1) dn++;
      tick;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL midload_quiet active_cycles=%0d required 0", dn);
    end
  endtask

  task automatic test_back_to_back;
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    do_start;
    load_all(0, 1'b0);
    check_run(1'b0);
    sb.delete();
    finish_idle(1'b1);
    do_start;
    va = '{8'd1, 8'd0, 8'd0, 8'd1};
    ep = '{5, 6, 7, 8};
    load_all(0, 1'b0);
    check_run(1'b0);
    check_mats;
    check_product;
    finish_idle(1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sign_ext;
    test_backpressure;
    test_start_ignored;
    test_reset_mid_load;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mat_loader.md
Name: mat_loader

Overview:
- Upstream stage of mat_mult.
- Accepts matrix elements one per handshake on a valid/ready stream: first A in row-major order, then B in row-major order.
- Builds the two N×N int operand arrays, storing B transposed so that mat_mult's row-by-row dot products compute A×B.
- After loading, holds the operands stable and drives mat_mult's enable for a fixed number of cycles, then pulses done.

Parameters:
- N, 2, matrix dimension; must match the mat_mult instance.
- DW, 8, bit width of each streamed element; must match the mat_mult instance.
- RUN_CYCLES, 4, number of cycles enable is held high per computation; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low; asserted when reset==0 at a rising clk edge.
- start  in  1  begin a load; sampled only in IDLE.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  DW  signed element; sign-extended to int on capture.
- in_ready  out  1  loader accepts an element this cycle.
- busy  out  1  high in every state except IDLE.
- enable  out  1  connects to mat_mult enable.
- done  out  1  one-cycle pulse when a run completes.
- mat1  out  int [0:N-1][0:N-1]  A operand, row-major.
- mat2  out  int [0:N-1][0:N-1]  B transposed: mat2[j][k] = B[k][j].

Behaviour:
- All outputs are registered. in_ready and busy are decoded directly from the registered state.
- Reset (reset==0 at a clk edge), from any state including mid-load or mid-run:
  - state = IDLE, element counter = 0.
  - All mat1/mat2 entries = 0.
  - in_ready = 0, busy = 0, enable = 0, done = 0.
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE.
- IDLE:
  - in_ready = 0.
  - start = 1 → LOAD_A next cycle with counter = 0.
  - start is ignored in every other state.
- LOAD_A / LOAD_B:
  - in_ready = 1. A transfer occurs when in_valid && in_ready.
  - idx = counter, row = idx / N, col = idx % N.
  - LOAD_A writes mat1[row][col] = sext(in_data).
  - LOAD_B writes mat2[col][row] = sext(in_data).
  - The counter increments by 1 on each transfer only; in_valid = 0 stalls indefinitely with no change.
  - Transfer at idx = N*N-1: counter wraps to 0 and the state advances (LOAD_A → LOAD_B, LOAD_B → RUN) on the next cycle. There is no gap cycle: in_ready stays 1 across the A→B boundary.
- RUN:
  - in_ready = 0; enable = 1 for exactly RUN_CYCLES consecutive cycles, tracked by a separate run counter.
  - After the last RUN cycle → DONE.
  - mat1 and mat2 do not change during RUN.
- DONE:
  - done = 1 for exactly one cycle, enable = 0, then → IDLE.
  - start asserted in the DONE cycle is ignored.
- Operands persist in IDLE after a run. A new load overwrites entries progressively; entries are not cleared at start.
- Data width: sign extension from DW to 32 bits. DW = 32 passes data through unchanged.
- Latency: start accepted at cycle t, input continuously valid → in_ready rises at t+1, last B element is accepted at t+2N², enable goes high the cycle after that, and done pulses RUN_CYCLES cycles after enable first goes high.

Decomposition:
- Shared package mat_pkg holds:
  - typedef loader_state_e (the five states).
  - Parameterised matrix typedef int [0:N-1][0:N-1], or its convention when parameterised typedefs are not used.
  - Helper functions idx_row and idx_col.
- The block is a single module with no sub-module. The FSM, element counter, run counter and operand registers are all inline.

Test Plan:
1. N=2, DW=8, RUN_CYCLES=4, start, then stream 1,2,3,4,5,6,7,8 with in_valid held high → mat1 = {{1,2},{3,4}}, mat2 = {{5,7},{6,8}}; enable high exactly 4 cycles; done pulses once; through a downstream mat_mult the product is {{19,22},{43,50}}.
2. Sign extension: stream 8'hFF and 8'h80 as A[0][0] and A[0][1] → mat1[0][0] = -1, mat1[0][1] = -128.
3. Backpressure: in_valid toggles 1,0,0,1,… → only handshaken elements are written; counter and state are unchanged during gaps; final matrices are identical to scenario 1.
4. start pulsed during LOAD_B and during RUN → no effect; the sequence completes normally with a single done pulse.
5. reset=0 for one cycle on the 3rd element of B → next cycle: state IDLE, all matrix entries 0, enable/in_ready/busy = 0, done never pulses.
6. Back-to-back runs: start in the cycle after DONE, load an identity matrix for A and the scenario-1 values for B → mat2 = {{5,7},{6,8}} and mat1 = {{1,0},{0,1}}, with no stale data after the load completes.
